// File: rtl/uart_tx_scheduler_if.sv
// Bundle of the requester-side and UART-side signals of the UART transmit scheduler.
// The scheduler uses the slave modport; the requesters/UART environment use master.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_len;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic                 byte_taken;
    logic                 pkt_done;
    logic                 pkt_err;
    logic                 cts_hold;
    logic                 uart_busy;
    logic                 uart_tx_done;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;

    modport slave (
        input  req, req_len, req_data, cts_hold, uart_busy, uart_tx_done,
        output grant, byte_taken, pkt_done, pkt_err, uart_transmit, uart_tx_byte
    );

    modport master (
        output req, req_len, req_data, cts_hold, uart_busy, uart_tx_done,
        input  grant, byte_taken, pkt_done, pkt_err, uart_transmit, uart_tx_byte
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler sharing one UART transmitter among NUM_REQ requesters,
// pacing bytes on tx_done, honouring cts_hold and aborting a packet on UART timeout.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_LOAD      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         remaining_q, remaining_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [11:0]        wd_q, wd_d;
    logic               transmit_q, transmit_d;
    logic               taken_q, taken_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [PW-1:0]      sel_s;
    logic [PW-1:0]      cand_s;
    logic               found_s;
    logic [7:0]         len_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first set req bit at or above rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        cand_s  = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && bus.req[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                found_s = found_s;
            end
            cand_s = (cand_s == PW'(NUM_REQ - 1)) ? '0 : cand_s + PW'(1);
        end
        len_s = bus.req_len[{sel_s, 3'b000} +: 8];
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        remaining_d = remaining_q;
        tx_byte_d   = tx_byte_q;
        wd_d        = wd_q;
        transmit_d  = 1'b0;
        taken_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                // A request that vanished before arbitration simply returns to idle.
                if (found_s) begin
                    grant_d     = onehot(sel_s);
                    sel_d       = sel_s;
                    remaining_d = len_s;
                    rr_ptr_d    = (sel_s == PW'(NUM_REQ - 1)) ? '0 : sel_s + PW'(1);
                    state_d     = (len_s == 8'd0) ? S_FINISH : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!bus.cts_hold && !bus.uart_busy) begin
                    tx_byte_d   = bus.req_data[{sel_q, 3'b000} +: 8];
                    transmit_d  = 1'b1;
                    taken_d     = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    wd_d        = 12'd0;
                    state_d     = S_WAIT_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WAIT_DONE: begin
                wd_d = wd_q + 12'd1;
                if (bus.uart_tx_done) begin
                    state_d = (remaining_q != 8'd0) ? S_LOAD : S_FINISH;
                end else if (wd_q == 12'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            grant_q     <= '0;
            remaining_q <= 8'd0;
            tx_byte_q   <= 8'h00;
            wd_q        <= 12'd0;
            transmit_q  <= 1'b0;
            taken_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            remaining_q <= remaining_d;
            tx_byte_q   <= tx_byte_d;
            wd_q        <= wd_d;
            transmit_q  <= transmit_d;
            taken_q     <= taken_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.byte_taken    = taken_q;
    assign bus.pkt_done      = done_q;
    assign bus.pkt_err       = err_q;
    assign bus.uart_transmit = transmit_q;
    assign bus.uart_tx_byte  = tx_byte_q;
endmodule
